// File: rtl/shift_add_mul16.sv
// Sequential 16x16 -> 16-bit unsigned shift-and-add multiplier with sticky overflow.
// Each RUN cycle adds (A << i) into the accumulator when bit i of B is set; exits early once no set bits remain.
module shift_add_mul16 #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] P,
  output logic             OVF,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [CNT_W-1:0]   i_q, i_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   p_q, p_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [2*WIDTH-1:0] wide_s;
  logic [WIDTH-1:0]   shift_out_s;
  logic               lost_s;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH-1:0]   remain_s;
  logic               last_s;

  // Shifter, partial-product sum and exit detection for the current bit index.
  always_comb begin
    wide_s      = {{WIDTH{1'b0}}, a_q} << i_q;
    shift_out_s = wide_s[WIDTH-1:0];
    // Upper half holds exactly the multiplicand bits pushed out by the shift.
    lost_s      = |wide_s[2*WIDTH-1:WIDTH];
    sum_s       = {1'b0, acc_q} + {1'b0, shift_out_s};
    remain_s    = (b_q >> i_q) >> 1;
    last_s      = (i_q == {CNT_W{1'b1}}) || (remain_s == {WIDTH{1'b0}});
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    i_d     = i_q;
    acc_d   = acc_q;
    p_d     = p_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          i_d     = {CNT_W{1'b0}};
          acc_d   = {WIDTH{1'b0}};
          ovf_d   = 1'b0;
          state_d = S_RUN;
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        if (b_q[i_q]) begin
          acc_d = sum_s[WIDTH-1:0];
          ovf_d = ovf_q | sum_s[WIDTH] | lost_s;
        end else begin
          acc_d = acc_q;
        end
        if (last_s) begin
          p_d     = acc_d;
          state_d = S_DONE;
        end else begin
          i_d     = i_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State registers; reset dominates start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      i_q     <= {CNT_W{1'b0}};
      acc_q   <= {WIDTH{1'b0}};
      p_q     <= {WIDTH{1'b0}};
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      i_q     <= i_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign P    = p_q;
  assign OVF  = ovf_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_shift_add_mul16.sv
// Scoreboard bench for shift_add_mul16: stimulus pushes expected results, a monitor pops on each done rise.
module tb_shift_add_mul16;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] P;
  logic        OVF;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic [15:0] p;
    logic        ovf;
    logic [4:0]  len;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   run_cnt  = 0;
  logic done_prev = 1'b0;

  shift_add_mul16 dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .A    (A),
    .B    (B),
    .P    (P),
    .OVF  (OVF),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: exclusivity of busy/done, RUN length, and result on every done rise.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      checks++;
      if (busy && done) begin
        failures++;
        $display("FAIL busy_done_excl busy=%0b done=%0b required not both high", busy, done);
      end
    end
    if (busy) begin
      run_cnt++;
    end else begin
      if (done && !done_prev) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done P=%h with empty scoreboard", P);
        end else begin
          e = sb.pop_front();
          if (P !== e.p) begin
            failures++;
            $display("FAIL result_P got=%h required=%h", P, e.p);
          end
          checks++;
          if (OVF !== e.ovf) begin
            failures++;
            $display("FAIL result_OVF got=%0b required=%0b (P=%h)", OVF, e.ovf, e.p);
          end
          checks++;
          if (run_cnt != int'(e.len)) begin
            failures++;
            $display("FAIL run_len got=%0d required=%0d (P=%h)", run_cnt, e.len, e.p);
          end
        end
      end
      run_cnt = 0;
    end
    done_prev = done;
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] ep, input logic eo, input int elen);
    exp_t e;
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    e.p = ep;
    e.ovf = eo;
    e.len = elen[4:0];
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    A = 16'hDEAD;
    B = 16'hBEEF;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout done=%0b required 1 within 40 cycles", done);
    end
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  task automatic run_model(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] prod;
    int          len;
    prod = {16'h0000, a} * {16'h0000, b};
    len  = 1;
    for (int j = 0; j < 16; j++) begin
      if (b[j]) len = j + 1;
    end
    issue(a, b, prod[15:0], (prod[31:16] != 16'h0000), len);
    wait_done();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    A = 16'h0000;
    B = 16'h0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_P", P, 16'h0000);
    chk("reset_OVF", {15'h0, OVF}, 16'h0000);
    chk("reset_busy", {15'h0, busy}, 16'h0000);
    chk("reset_done", {15'h0, done}, 16'h0000);

    // Basic multiply, then outputs must hold through idle cycles.
    issue(16'd3, 16'd5, 16'h000F, 1'b0, 3);
    wait_done();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("hold_P", P, 16'h000F);
      chk("hold_done", {15'h0, done}, 16'h0001);
    end

    issue(16'h1234, 16'h0000, 16'h0000, 1'b0, 1);
    wait_done();
    issue(16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 9);
    wait_done();
    issue(16'h8000, 16'h0002, 16'h0000, 1'b1, 2);
    wait_done();
    issue(16'h7FFF, 16'h0003, 16'h7FFD, 1'b1, 2);
    wait_done();
    issue(16'hFFFF, 16'h8000, 16'h8000, 1'b1, 16);
    wait_done();

    // start hammered during RUN with junk operands must not disturb the result.
    issue(16'd6, 16'd7, 16'h002A, 1'b0, 3);
    for (int k = 0; k < 40; k++) begin
      if (busy) begin
        start = 1'b1;
        A = 16'($urandom);
        B = 16'($urandom);
        @(negedge clk);
      end else begin
        start = 1'b0;
        break;
      end
    end
    start = 1'b0;
    wait_done();
    // Back-to-back start straight out of DONE.
    issue(16'h0010, 16'h0010, 16'h0100, 1'b0, 5);
    chk("b2b_busy", {15'h0, busy}, 16'h0001);
    chk("b2b_done", {15'h0, done}, 16'h0000);
    wait_done();

    // Reset on the 5th RUN cycle; no result is expected for this operation.
    @(negedge clk);
    A = 16'h0101;
    B = 16'hFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_busy", {15'h0, busy}, 16'h0001);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrun_reset_busy", {15'h0, busy}, 16'h0000);
    chk("midrun_reset_done", {15'h0, done}, 16'h0000);
    chk("midrun_reset_P", P, 16'h0000);
    chk("midrun_reset_OVF", {15'h0, OVF}, 16'h0000);
    issue(16'd2, 16'd3, 16'h0006, 1'b0, 2);
    wait_done();

    for (int n = 0; n < 1000; n++) begin
      run_model(16'($urandom), 16'($urandom));
    end

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
